alu_exec_unit: RTL



---
 rtl/alu_exec_unit_pkg.sv | 26 ++
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_shift_step.sv | 25 ++
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control encoding and execute-unit state types.
// The alu_ctrl codes must stay identical to the decoder's encoding.
package alu_exec_unit_pkg;

  localparam int ALU_CTRL_BITS = 4;

  localparam logic [ALU_CTRL_BITS-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_AND  = 4'd9;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  typedef enum logic [1:0] {SK_LL, SK_RL, SK_RA} shift_kind_e;

  function automatic logic is_shift_op(input logic [ALU_CTRL_BITS-1:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between ID-EX register, execute unit and EX-MEM register.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  import alu_exec_unit_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [ALU_CTRL_BITS-1:0] alu_ctrl;
  logic [XLEN-1:0]          a;
  logic [XLEN-1:0]          b;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          result;
  logic                     zero;
  logic                     illegal;

  modport master (
    output in_valid, alu_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

endinterface

// File: rtl/alu_shift_step.sv
// Combinational barrel stage: shifts by 0..SHIFT_STEP positions, logical or arithmetic.
module alu_shift_step
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  parameter int AMT_BITS   = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0]     value,
  input  logic [AMT_BITS-1:0] amt,
  input  shift_kind_e         kind,
  output logic [XLEN-1:0]     shifted
);

  always_comb begin
    shifted = value;
    case (kind)
      SK_LL:   shifted = value << amt;
      SK_RL:   shifted = value >> amt;
      SK_RA:   shifted = XLEN'($signed(value) >>> amt);
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops inline, shifts iterated SHIFT_STEP bits per cycle,
// registered result with valid/ready output and flush abort.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_exec_unit_if.slave    bus
);

  localparam int AMT_BITS = $clog2(SHIFT_STEP + 1);

  state_e          state, state_n;
  logic [XLEN-1:0] work, work_n;
  logic [4:0]      rem, rem_n;
  shift_kind_e     kind, kind_n;
  logic [XLEN-1:0] res, res_n;
  logic            zero_flag, zero_flag_n;
  logic            illegal_flag, illegal_flag_n;
  logic            valid, valid_n;

  logic            in_ready;
  logic            accept;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [5:0]      step;
  logic [XLEN-1:0] step_out;

  assign shamt    = bus.b[4:0];
  assign in_ready = (state == ST_IDLE) && !flush && (!valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Shift codes only reach this path with shamt==0; nonzero amounts go to the iterative stage.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.alu_ctrl)
      ALU_ADD:  alu_res = bus.a + bus.b;
      ALU_SUB:  alu_res = bus.a - bus.b;
      ALU_SLT:  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      ALU_SLTU: alu_res = XLEN'(bus.a < bus.b);
      ALU_XOR:  alu_res = bus.a ^ bus.b;
      ALU_OR:   alu_res = bus.a | bus.b;
      ALU_AND:  alu_res = bus.a & bus.b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.a;
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    if (int'(rem) > SHIFT_STEP) step = 6'(SHIFT_STEP);
    else                        step = {1'b0, rem};
  end

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .AMT_BITS   (AMT_BITS)
  ) u_shift_step (
    .value   (work),
    .amt     (AMT_BITS'(step)),
    .kind    (kind),
    .shifted (step_out)
  );

  always_comb begin
    state_n        = state;
    work_n         = work;
    rem_n          = rem;
    kind_n         = kind;
    res_n          = res;
    zero_flag_n    = zero_flag;
    illegal_flag_n = illegal_flag;
    valid_n        = valid;

    if (valid && bus.out_ready) valid_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(bus.alu_ctrl) && (shamt != 5'd0)) begin
            state_n = ST_SHIFT;
            work_n  = bus.a;
            rem_n   = shamt;
            if (bus.alu_ctrl == ALU_SLL)      kind_n = SK_LL;
            else if (bus.alu_ctrl == ALU_SRL) kind_n = SK_RL;
            else                              kind_n = SK_RA;
          end else begin
            res_n          = alu_res;
            zero_flag_n    = (alu_res == '0);
            illegal_flag_n = alu_ill;
            valid_n        = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_n = step_out;
        rem_n  = rem - step[4:0];
        if (step[4:0] == rem) begin
          state_n        = ST_IDLE;
          res_n          = step_out;
          zero_flag_n    = (step_out == '0);
          illegal_flag_n = 1'b0;
          valid_n        = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (flush) begin
      state_n = ST_IDLE;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      work         <= '0;
      rem          <= '0;
      kind         <= SK_LL;
      res          <= '0;
      zero_flag    <= 1'b1;
      illegal_flag <= 1'b0;
      valid        <= 1'b0;
    end else begin
      state        <= state_n;
      work         <= work_n;
      rem          <= rem_n;
      kind         <= kind_n;
      res          <= res_n;
      zero_flag    <= zero_flag_n;
      illegal_flag <= illegal_flag_n;
      valid        <= valid_n;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid;
  assign bus.result    = res;
  assign bus.zero      = zero_flag;
  assign bus.illegal   = illegal_flag;

endmodule
